// File: rtl/parrot_pkg.sv
// parrot_pkg: shared animation defaults, speed encoding and button-B FSM states
package parrot_pkg;
  localparam int NUM_FRAMES_DEF = 10;
  localparam int FRAME_WORDS_DEF = 16384;
  localparam logic [1:0] SPEED_RST = 2'd2;
  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} bstate_e;
  // Speed s steps every 1<<(3-s) frames; returns the last divider count before a step
  function automatic logic [2:0] div_limit(input logic [1:0] spd);
    return 3'((4'd1 << (2'd3 - spd)) - 4'd1);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, level debouncer and press/release pulse generator
module btn_debounce #(
  parameter int DEB_CYCLES = 90000
) (
  input  logic i_clk,
  input  logic i_res,
  input  logic i_btn_n,
  output logic o_press,
  output logic o_release
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic s1_q, s2_q, deb_q, deb_d, press_q, press_d, rel_q, rel_d, flip;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    flip = (s2_q != deb_q) && (cnt_q == CW'(DEB_CYCLES - 1));
    cnt_d = (s2_q == deb_q || flip) ? '0 : cnt_q + 1'b1;
    deb_d = flip ? s2_q : deb_q;
    press_d = flip & deb_q;
    rel_d = flip & ~deb_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      deb_q <= 1'b1;
      cnt_q <= '0;
      press_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      s1_q <= i_btn_n;
      s2_q <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
      press_q <= press_d;
      rel_q <= rel_d;
    end
  end
  assign o_press = press_q;
  assign o_release = rel_q;
endmodule

// File: rtl/parrot_anim_sequencer.sv
// parrot_anim_sequencer: vsync-paced animation frame index with speed, pause and reverse buttons
module parrot_anim_sequencer
  import parrot_pkg::*;
#(
  parameter int NUM_FRAMES  = NUM_FRAMES_DEF,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int ADDR_W      = 18,
  parameter int DEB_CYCLES  = 90000,
  parameter int LONG_FRAMES = 60
) (
  input  logic              i_clk,
  input  logic              i_res,
  input  logic              i_vsync_n,
  input  logic              i_btn_a_n,
  input  logic              i_btn_b_n,
  output logic [3:0]        o_frame_idx,
  output logic [ADDR_W-1:0] o_frame_base,
  output logic [1:0]        o_speed,
  output logic              o_paused,
  output logic              o_reverse,
  output logic              o_frame_tick
);
  localparam int LW = $clog2(LONG_FRAMES + 1);
  localparam logic [3:0] LAST = 4'(NUM_FRAMES - 1);
  logic a_press, a_rel_unused, b_press, b_rel, fe;
  logic vs_q, paused_q, paused_d, rev_q, rev_d, tick_q, tick_d;
  logic pause_tgl, rev_tgl, run, step;
  logic [1:0] spd_q, spd_d;
  logic [2:0] div_q, div_d;
  logic [3:0] idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LW-1:0] lp_q, lp_d;
  bstate_e st_q, st_d;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .i_clk(i_clk), .i_res(i_res), .i_btn_n(i_btn_a_n), .o_press(a_press), .o_release(a_rel_unused)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .i_clk(i_clk), .i_res(i_res), .i_btn_n(i_btn_b_n), .o_press(b_press), .o_release(b_rel)
  );
  assign fe = vs_q & ~i_vsync_n;
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      st_q <= ST_IDLE;
      lp_q <= '0;
    end else begin
      st_q <= st_d;
      lp_q <= lp_d;
    end
  end
  always_comb begin
    st_d = st_q;
    lp_d = lp_q;
    case (st_q)
      ST_IDLE: begin
        st_d = b_press ? ST_HELD : ST_IDLE;
        lp_d = b_press ? '0 : lp_q;
      end
      ST_HELD: begin
        st_d = b_rel ? ST_IDLE : (fe && lp_q == LW'(LONG_FRAMES - 1)) ? ST_LONG : ST_HELD;
        lp_d = (!b_rel && fe) ? lp_q + 1'b1 : lp_q;
      end
      ST_LONG: st_d = b_rel ? ST_IDLE : ST_LONG;
      default: st_d = ST_IDLE;
    endcase
  end
  // Release beats a simultaneous long-press threshold, so each press yields exactly one action
  always_comb begin
    pause_tgl = (st_q == ST_HELD) && b_rel;
    rev_tgl = (st_q == ST_HELD) && !b_rel && fe && (lp_q == LW'(LONG_FRAMES - 1));
  end
  always_comb begin
    paused_d = paused_q ^ pause_tgl;
    rev_d = rev_q ^ rev_tgl;
    run = fe & ~paused_q & ~paused_d & ~a_press;
    step = run && (div_q == div_limit(spd_q));
    spd_d = spd_q + 2'(a_press);
    div_d = (a_press || step) ? 3'd0 : run ? div_q + 3'd1 : div_q;
    idx_d = !step ? idx_q
          : rev_q ? ((idx_q == 4'd0) ? LAST : idx_q - 4'd1)
          : ((idx_q == LAST) ? 4'd0 : idx_q + 4'd1);
    base_d = ADDR_W'(idx_d * FRAME_WORDS);
    tick_d = step;
  end
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      vs_q <= 1'b1;
      paused_q <= 1'b0;
      rev_q <= 1'b0;
      tick_q <= 1'b0;
      spd_q <= SPEED_RST;
      div_q <= '0;
      idx_q <= '0;
      base_q <= '0;
    end else begin
      vs_q <= i_vsync_n;
      paused_q <= paused_d;
      rev_q <= rev_d;
      tick_q <= tick_d;
      spd_q <= spd_d;
      div_q <= div_d;
      idx_q <= idx_d;
      base_q <= base_d;
    end
  end
  assign o_frame_idx = idx_q;
  assign o_frame_base = base_q;
  assign o_speed = spd_q;
  assign o_paused = paused_q;
  assign o_reverse = rev_q;
  assign o_frame_tick = tick_q;
endmodule

// File: tb/tb_parrot_anim_sequencer.sv
// tb_parrot_anim_sequencer: directed vectors plus randomized run against a frame-level reference model
module tb_parrot_anim_sequencer;
  localparam int DEB = 4;
  localparam int LONG = 3;
  localparam int NF = 10;
  localparam int FW = 16384;
  logic clk = 1'b0;
  logic res, vs, a, b;
  logic [3:0] o_frame_idx;
  logic [17:0] o_frame_base;
  logic [1:0] o_speed;
  logic o_paused, o_reverse, o_frame_tick;
  int checks = 0, errors = 0;
  int m_vs, m_idx, m_spd, m_pau, m_rev, m_tick, m_frames, b_down, b_frames, b_long;
  int s1[2], s2[2], deb[2], run[2], prs[2], rel[2];
  typedef struct {int a_n; int exp_idx; int exp_spd;} vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  parrot_anim_sequencer #(.ADDR_W(18), .DEB_CYCLES(DEB), .LONG_FRAMES(LONG)) dut (
    .i_clk(clk), .i_res(res), .i_vsync_n(vs), .i_btn_a_n(a), .i_btn_b_n(b),
    .o_frame_idx(o_frame_idx), .o_frame_base(o_frame_base), .o_speed(o_speed),
    .o_paused(o_paused), .o_reverse(o_reverse), .o_frame_tick(o_frame_tick)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // A button level is accepted after DEB consecutive synchronised samples disagree with it
  task automatic deb_step(input int k, input int pin);
    prs[k] = 0;
    rel[k] = 0;
    if (s2[k] != deb[k]) begin
      run[k]++;
      if (run[k] == DEB) begin
        deb[k] = s2[k];
        run[k] = 0;
        prs[k] = int'(deb[k] == 0);
        rel[k] = int'(deb[k] == 1);
      end
    end else run[k] = 0;
    s2[k] = s1[k];
    s1[k] = pin;
  endtask

  task automatic model_step();
    int pa, pb, rb, fe, ptg, rtg, np;
    if (res) begin
      m_vs = 1;
      for (int k = 0; k < 2; k++) begin
        s1[k] = 1; s2[k] = 1; deb[k] = 1; run[k] = 0; prs[k] = 0; rel[k] = 0;
      end
      m_idx = 0; m_spd = 2; m_pau = 0; m_rev = 0; m_tick = 0; m_frames = 0;
      b_down = 0; b_frames = 0; b_long = 0;
      return;
    end
    pa = prs[0]; pb = prs[1]; rb = rel[1];
    fe = int'(m_vs == 1 && vs == 1'b0);
    ptg = 0; rtg = 0;
    if (b_down != 0) begin
      if (rb != 0) begin
        b_down = 0;
        ptg = int'(b_long == 0);
      end else if (fe != 0 && b_long == 0) begin
        b_frames++;
        if (b_frames == LONG) begin rtg = 1; b_long = 1; end
      end
    end else if (pb != 0) begin
      b_down = 1; b_frames = 0; b_long = 0;
    end
    np = m_pau ^ ptg;
    m_tick = 0;
    if (pa != 0) begin
      m_spd = (m_spd + 1) % 4;
      m_frames = 0;
    end else if (fe != 0 && m_pau == 0 && np == 0) begin
      m_frames++;
      if (m_frames == (8 >> m_spd)) begin
        m_frames = 0;
        m_idx = (m_rev != 0) ? (m_idx + NF - 1) % NF : (m_idx + 1) % NF;
        m_tick = 1;
      end
    end
    m_rev ^= rtg;
    m_pau = np;
    m_vs = int'(vs);
    deb_step(0, int'(a));
    deb_step(1, int'(b));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("m_idx", int'(o_frame_idx), m_idx);
    chk("m_base", int'(o_frame_base), m_idx * FW);
    chk("m_speed", int'(o_speed), m_spd);
    chk("m_paused", int'(o_paused), m_pau);
    chk("m_reverse", int'(o_reverse), m_rev);
    chk("m_tick", int'(o_frame_tick), m_tick);
  endtask

  task automatic frame();
    vs = 1'b0; cyc();
    vs = 1'b1; cyc(); cyc(); cyc();
  endtask

  task automatic press_a();
    a = 1'b0; repeat (10) cyc();
    a = 1'b1; repeat (10) cyc();
  endtask

  task automatic hold_b(input int frames);
    b = 1'b0; repeat (10) cyc();
    for (int i = 0; i < frames; i++) frame();
    b = 1'b1; repeat (10) cyc();
  endtask

  initial begin
    int vcnt, adur, bdur;
    res = 1'b1; vs = 1'b1; a = 1'b1; b = 1'b1;
    vecs[0] = '{1, 0, 2}; vecs[1] = '{1, 1, 2}; vecs[2] = '{1, 1, 2}; vecs[3] = '{1, 2, 2};
    vecs[4] = '{1, 2, 2}; vecs[5] = '{1, 3, 2}; vecs[6] = '{1, 3, 2}; vecs[7] = '{1, 4, 2};
    cyc(); cyc();
    res = 1'b0;
    cyc();
    chk("rst_idx", int'(o_frame_idx), 0);
    chk("rst_base", int'(o_frame_base), 0);
    chk("rst_speed", int'(o_speed), 2);
    chk("rst_paused", int'(o_paused), 0);
    chk("rst_reverse", int'(o_reverse), 0);
    chk("rst_tick", int'(o_frame_tick), 0);
    foreach (vecs[i]) begin
      a = vecs[i].a_n[0];
      frame();
      chk("vec_idx", int'(o_frame_idx), vecs[i].exp_idx);
      chk("vec_base", int'(o_frame_base), vecs[i].exp_idx * FW);
      chk("vec_speed", int'(o_speed), vecs[i].exp_spd);
    end
    press_a();
    chk("speed_to3", int'(o_speed), 3);
    repeat (5) frame();
    chk("idx_9", int'(o_frame_idx), 9);
    vs = 1'b0; cyc();
    chk("wrap_idx", int'(o_frame_idx), 0);
    chk("wrap_tick_hi", int'(o_frame_tick), 1);
    vs = 1'b1; cyc();
    chk("wrap_tick_lo", int'(o_frame_tick), 0);
    cyc(); cyc();
    b = 1'b0; repeat (10) cyc();
    frame(); frame();
    chk("long_pre_rev", int'(o_reverse), 0);
    vs = 1'b0; cyc();
    chk("long_rev_at3", int'(o_reverse), 1);
    chk("long_idx3", int'(o_frame_idx), 3);
    vs = 1'b1; cyc(); cyc(); cyc();
    frame();
    chk("long_idx_rev", int'(o_frame_idx), 2);
    b = 1'b1; repeat (10) cyc();
    chk("long_no_pause", int'(o_paused), 0);
    frame(); frame(); frame();
    chk("rev_wrap", int'(o_frame_idx), 9);
    for (int i = 0; i < 4; i++) begin
      press_a();
      chk("speed_cycle", int'(o_speed), i);
    end
    a = 1'b0; cyc(); cyc();
    a = 1'b1; repeat (10) cyc();
    chk("glitch_speed", int'(o_speed), 3);
    hold_b(2);
    chk("pause_on", int'(o_paused), 1);
    chk("pause_idx", int'(o_frame_idx), 7);
    repeat (5) frame();
    chk("pause_frozen", int'(o_frame_idx), 7);
    hold_b(2);
    chk("pause_off", int'(o_paused), 0);
    chk("pause_off_idx", int'(o_frame_idx), 7);
    frame();
    chk("resume_idx", int'(o_frame_idx), 6);
    press_a(); press_a(); press_a();
    chk("speed_back2", int'(o_speed), 2);
    frame();
    chk("div1_idx", int'(o_frame_idx), 6);
    b = 1'b0; repeat (10) cyc();
    res = 1'b1; b = 1'b1;
    cyc();
    chk("mid_rst_idx", int'(o_frame_idx), 0);
    chk("mid_rst_speed", int'(o_speed), 2);
    chk("mid_rst_reverse", int'(o_reverse), 0);
    chk("mid_rst_paused", int'(o_paused), 0);
    res = 1'b0;
    frame();
    chk("post_rst_f1", int'(o_frame_idx), 0);
    frame();
    chk("post_rst_f2", int'(o_frame_idx), 1);
    vcnt = 0; adur = 0; bdur = 0;
    for (int i = 0; i < 4000; i++) begin
      vs = (vcnt == 0) ? 1'b0 : 1'b1;
      vcnt = (vcnt == 0) ? int'($urandom_range(2, 6)) : vcnt - 1;
      if (adur == 0) begin a = ~a; adur = int'($urandom_range(1, 25)); end else adur--;
      if (bdur == 0) begin b = ~b; bdur = int'($urandom_range(1, 40)); end else bdur--;
      res = ($urandom_range(0, 999) == 0);
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
